note_ram_ctrl: RTL and testbench

//  Sits between the UART receiver and the single-port note RAM; the playback sequencer also reads that RAM.

---
 rtl/note_pkg.sv | 25 ++
 rtl/note_ram_ctrl_if.sv | 41 ++++
 rtl/word_fifo.sv | 56 +++++
 rtl/note_ram_ctrl.sv | 162 ++++++++++++++++
 tb/tb_note_ram_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the note RAM loader slice.
//   NOTE_W      : width of one packed note word
//   pk_state_e  : byte-packer state encodings
//   pack_w0/w1  : split three received bytes into two 12-bit note words
package note_pkg;

  localparam int unsigned NOTE_W = 12;

  typedef enum logic [1:0] {
    PK_B0 = 2'd0,
    PK_B1 = 2'd1,
    PK_B2 = 2'd2
  } pk_state_e;

  // First word: all of byte 0 plus the high nibble of byte 1.
  function automatic logic [NOTE_W-1:0] pack_w0(input logic [7:0] b0, input logic [7:0] b1);
    return {b0, b1[7:4]};
  endfunction

  // Second word: low nibble of byte 1 plus all of byte 2.
  function automatic logic [NOTE_W-1:0] pack_w1(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[3:0], b2};
  endfunction

endpackage

// File: rtl/note_ram_ctrl_if.sv
// Bus bundle for note_ram_ctrl.
//   UART side   : rx_valid, rx_byte, load_start
//   Player side : play_req, play_addr -> play_gnt, play_valid, play_data
//   RAM side    : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
//   Status      : word_count, mem_full, overflow
// slave  = the controller, master = its surroundings (UART, player, RAM).
interface note_ram_ctrl_if
  import note_pkg::*;
#(
  parameter int unsigned AW = 8
);
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              load_start;
  logic              play_req;
  logic [AW-1:0]     play_addr;
  logic              play_gnt;
  logic              play_valid;
  logic [NOTE_W-1:0] play_data;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [NOTE_W-1:0] ram_wdata;
  logic [NOTE_W-1:0] ram_rdata;
  logic [AW:0]       word_count;
  logic              mem_full;
  logic              overflow;

  modport slave (
    input  rx_valid, rx_byte, load_start, play_req, play_addr, ram_rdata,
    output play_gnt, play_valid, play_data, ram_en, ram_we, ram_addr, ram_wdata,
           word_count, mem_full, overflow
  );

  modport master (
    output rx_valid, rx_byte, load_start, play_req, play_addr, ram_rdata,
    input  play_gnt, play_valid, play_data, ram_en, ram_we, ram_addr, ram_wdata,
           word_count, mem_full, overflow
  );

endinterface

// File: rtl/word_fifo.sv
// Dual-push / single-pop word FIFO.
//   clr            : synchronous flush (wins over push/pop)
//   push2,din0/1   : push two words in one cycle (din0 first); caller ensures free_cnt >= 2
//   pop            : drop the head; caller ensures not empty
//   free_cnt,empty,head : occupancy status and current head word
// DEPTH must be a power of 2 so the pointers wrap naturally.
module word_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push2,
  input  logic [WIDTH-1:0]         din0,
  input  logic [WIDTH-1:0]         din1,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   free_cnt,
  output logic                     empty,
  output logic [WIDTH-1:0]         head
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW:0]      r_count;

  assign free_cnt = (PW+1)'(DEPTH) - r_count;
  assign empty    = (r_count == '0);
  assign head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (push2 && !clr) begin
      r_mem[r_wr_ptr]           <= din0;
      r_mem[r_wr_ptr + PW'(1)]  <= din1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push2) r_wr_ptr <= r_wr_ptr + PW'(2);
      if (pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + ((PW+1)'(push2) << 1) - (PW+1)'(pop);
    end
  end

endmodule

// File: rtl/note_ram_ctrl.sv
// Note RAM controller: packs UART bytes into 12-bit note words (3 bytes ->
// 2 words), buffers them in word_fifo and writes them to sequential RAM
// addresses, sharing the single RAM port with the playback sequencer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : note_ram_ctrl_if.slave (UART, player, RAM and status signals)
// The player normally wins the RAM port; after STARVE_LIMIT consecutive
// denied cycles with words waiting, the loader is forced one grant.
module note_ram_ctrl
  import note_pkg::*;
#(
  parameter int unsigned AW           = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  note_ram_ctrl_if.slave   bus
);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0] CAPACITY = {1'b1, {AW{1'b0}}};

  pk_state_e         r_pk_state;
  pk_state_e         w_pk_next;
  logic [7:0]        r_b0;
  logic [7:0]        r_b1;
  logic              w_push;
  logic              w_ovf_set;
  logic [NOTE_W-1:0] w_w0;
  logic [NOTE_W-1:0] w_w1;

  logic [FCW-1:0]    w_free_cnt;
  logic              w_empty;
  logic [NOTE_W-1:0] w_head;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_word_count;
  logic              r_overflow;
  logic [SCW-1:0]    r_starve;
  logic              r_play_valid;

  logic              w_mem_full;
  logic              w_ld_avail;
  logic              w_forced;
  logic              w_play_gnt;
  logic              w_pop;
  logic              w_write;
  logic [AW-1:0]     w_ram_addr;

  word_fifo #(
    .WIDTH (NOTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.load_start),
    .push2    (w_push),
    .din0     (w_w0),
    .din1     (w_w1),
    .pop      (w_pop),
    .free_cnt (w_free_cnt),
    .empty    (w_empty),
    .head     (w_head)
  );

  // ---------------- byte packer ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pk_state <= PK_B0;
    else        r_pk_state <= w_pk_next;
  end

  always_comb begin
    w_pk_next = r_pk_state;
    w_push    = 1'b0;
    w_ovf_set = 1'b0;
    w_w0      = pack_w0(r_b0, r_b1);
    w_w1      = pack_w1(r_b1, bus.rx_byte);
    if (bus.load_start) begin
      // A byte arriving with load_start is byte 0 of the new score.
      w_pk_next = bus.rx_valid ? PK_B1 : PK_B0;
    end else if (bus.rx_valid) begin
      unique case (r_pk_state)
        PK_B0: w_pk_next = PK_B1;
        PK_B1: w_pk_next = PK_B2;
        PK_B2: begin
          w_pk_next = PK_B0;
          // Occupancy before this cycle's pop decides whether the pair fits.
          if (w_free_cnt >= FCW'(2)) w_push    = 1'b1;
          else                       w_ovf_set = 1'b1;
        end
        default: w_pk_next = PK_B0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0 <= '0;
      r_b1 <= '0;
    end else if (bus.rx_valid) begin
      if (bus.load_start || r_pk_state == PK_B0) r_b0 <= bus.rx_byte;
      else if (r_pk_state == PK_B1)              r_b1 <= bus.rx_byte;
    end
  end

  // ---------------- RAM port arbiter ----------------
  always_comb begin
    w_mem_full = (r_word_count == CAPACITY);
    // The FIFO is being flushed under load_start, so the loader has nothing to offer.
    w_ld_avail = !w_empty && !bus.load_start;
    w_forced   = (r_starve == SCW'(STARVE_LIMIT)) && w_ld_avail;
    w_play_gnt = bus.play_req && !w_forced;
    w_pop      = !w_play_gnt && w_ld_avail;
    w_write    = w_pop && !w_mem_full;
    w_ram_addr = '0;
    if (w_play_gnt)   w_ram_addr = bus.play_addr;
    else if (w_write) w_ram_addr = r_wr_ptr;
  end

  assign bus.play_gnt   = w_play_gnt;
  assign bus.ram_en     = w_play_gnt || w_write;
  assign bus.ram_we     = w_write;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_wdata  = w_write ? w_head : '0;
  assign bus.play_valid = r_play_valid;
  assign bus.play_data  = r_play_valid ? bus.ram_rdata : '0;
  assign bus.word_count = r_word_count;
  assign bus.mem_full   = w_mem_full;
  assign bus.overflow   = r_overflow;

  // ---------------- counters and status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_starve     <= '0;
    end else if (bus.load_start) begin
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_starve     <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_word_count <= r_word_count + (AW+1)'(1);
      end
      if (w_ovf_set) r_overflow <= 1'b1;
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (w_play_gnt && r_starve != SCW'(STARVE_LIMIT))
        r_starve <= r_starve + SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_play_valid <= 1'b0;
    else        r_play_valid <= w_play_gnt;
  end

endmodule

// File: tb/tb_note_ram_ctrl.sv
module tb_note_ram_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  note_ram_ctrl_if #(.AW(8)) bus ();
  note_ram_ctrl_if #(.AW(2)) bus2 ();

  note_ram_ctrl #(.AW(8), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  note_ram_ctrl #(.AW(2), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [11:0] ram_mem [256];
  logic [11:0] ram_q;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      else            ram_q <= ram_mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata  = ram_q;
  assign bus2.ram_rdata = 12'h000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_valid = 0; bus.rx_byte = 0; bus.load_start = 0; bus.play_req = 0; bus.play_addr = 0;
    bus2.rx_valid = 0; bus2.rx_byte = 0; bus2.load_start = 0; bus2.play_req = 0; bus2.play_addr = 0;
    #2;
    n_tests++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en: got %0h want 0", bus.ram_en); end
    n_tests++; if (bus.word_count !== 9'd0) begin n_fail++; $display("FAIL reset_word_count: got %0h want 0", bus.word_count); end
    n_tests++; if ({bus.play_gnt, bus.play_valid, bus.mem_full, bus.overflow, bus.ram_we} !== 5'b0)
      begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {bus.play_gnt, bus.play_valid, bus.mem_full, bus.overflow, bus.ram_we}); end
    n_tests++; if ({bus.ram_addr, bus.ram_wdata, bus.play_data} !== 32'h0)
      begin n_fail++; $display("FAIL reset_buses: got %h want 0", {bus.ram_addr, bus.ram_wdata, bus.play_data}); end
    step(); step();
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  // 12 34 56 -> 0x123 at addr 0, 0x456 at addr 1 on consecutive cycles.
  task automatic test_pack_write();
    send_byte(8'h12);
    send_byte(8'h34);
    #1;
    n_tests++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL t1_idle_en: got %0h want 0", bus.ram_en); end
    send_byte(8'h56);
    #1;
    n_tests++; if ({bus.ram_en, bus.ram_we} !== 2'b11) begin n_fail++; $display("FAIL t1_we0: got %b want 11", {bus.ram_en, bus.ram_we}); end
    n_tests++; if (bus.ram_addr !== 8'd0) begin n_fail++; $display("FAIL t1_addr0: got %0h want 0", bus.ram_addr); end
    n_tests++; if (bus.ram_wdata !== 12'h123) begin n_fail++; $display("FAIL t1_data0: got %h want 123", bus.ram_wdata); end
    step(); #1;
    n_tests++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL t1_we1: got %0h want 1", bus.ram_we); end
    n_tests++; if (bus.ram_addr !== 8'd1) begin n_fail++; $display("FAIL t1_addr1: got %0h want 1", bus.ram_addr); end
    n_tests++; if (bus.ram_wdata !== 12'h456) begin n_fail++; $display("FAIL t1_data1: got %h want 456", bus.ram_wdata); end
    step(); #1;
    n_tests++; if (bus.ram_en !== 1'b0) begin n_fail++; $display("FAIL t1_done_en: got %0h want 0", bus.ram_en); end
    n_tests++; if (bus.word_count !== 9'd2) begin n_fail++; $display("FAIL t1_count: got %0d want 2", bus.word_count); end
    step();
  endtask

  task automatic test_read();
    bus.play_req = 1'b1; bus.play_addr = 8'd1;
    #1;
    n_tests++; if ({bus.play_gnt, bus.ram_en, bus.ram_we} !== 3'b110) begin n_fail++; $display("FAIL t3_gnt: got %b want 110", {bus.play_gnt, bus.ram_en, bus.ram_we}); end
    n_tests++; if (bus.ram_addr !== 8'd1) begin n_fail++; $display("FAIL t3_addr: got %0h want 1", bus.ram_addr); end
    n_tests++; if (bus.play_valid !== 1'b0) begin n_fail++; $display("FAIL t3_valid_early: got %0h want 0", bus.play_valid); end
    step();
    bus.play_req = 1'b0;
    #1;
    n_tests++; if (bus.play_valid !== 1'b1) begin n_fail++; $display("FAIL t3_valid: got %0h want 1", bus.play_valid); end
    n_tests++; if (bus.play_data !== 12'h456) begin n_fail++; $display("FAIL t3_data: got %h want 456", bus.play_data); end
    step(); #1;
    n_tests++; if (bus.play_valid !== 1'b0) begin n_fail++; $display("FAIL t3_valid_drop: got %0h want 0", bus.play_valid); end
    step();
  endtask

  // 8 player grants with words waiting, then one forced loader write.
  task automatic test_starvation();
    bus.play_req = 1'b1; bus.play_addr = 8'd0;
    send_byte(8'h9A);
    send_byte(8'hBC);
    send_byte(8'hDE);
    for (int i = 0; i < 8; i++) begin
      #1;
      n_tests++; if ({bus.play_gnt, bus.ram_we} !== 2'b10) begin n_fail++; $display("FAIL t2_grant%0d: got %b want 10", i, {bus.play_gnt, bus.ram_we}); end
      step();
    end
    #1;
    n_tests++; if ({bus.play_gnt, bus.ram_we} !== 2'b01) begin n_fail++; $display("FAIL t2_forced: got %b want 01", {bus.play_gnt, bus.ram_we}); end
    n_tests++; if ({bus.ram_addr, bus.ram_wdata} !== {8'd2, 12'h9AB}) begin n_fail++; $display("FAIL t2_forced_wr: got %h want 029ab", {bus.ram_addr, bus.ram_wdata}); end
    step(); #1;
    n_tests++; if (bus.play_gnt !== 1'b1) begin n_fail++; $display("FAIL t2_resume: got %0h want 1", bus.play_gnt); end
    step();
    bus.play_req = 1'b0;
    #1;
    n_tests++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 8'd3, 12'hCDE}) begin n_fail++; $display("FAIL t2_drain: got %h want 103cde", {bus.ram_we, bus.ram_addr, bus.ram_wdata}); end
    step(); #1;
    n_tests++; if (bus.word_count !== 9'd4) begin n_fail++; $display("FAIL t2_count: got %0d want 4", bus.word_count); end
    step();
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [9];
    int en_cycles;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    bus.play_req = 1'b1; bus.play_addr = 8'd5;
    bus.load_start = 1'b1;
    step();
    bus.load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_byte(bytes[i]);
      if (i == 5) begin
        #1;
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL t4_no_ovf: got %0h want 0", bus.overflow); end
      end
    end
    #1;
    n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL t4_ovf: got %0h want 1", bus.overflow); end
    n_tests++; if (bus.word_count !== 9'd0) begin n_fail++; $display("FAIL t4_count: got %0d want 0", bus.word_count); end
    bus.load_start = 1'b1;
    #1;
    n_tests++; if ({bus.play_gnt, bus.ram_we} !== 2'b10) begin n_fail++; $display("FAIL t4_ls_gnt: got %b want 10", {bus.play_gnt, bus.ram_we}); end
    step();
    bus.load_start = 1'b0;
    bus.play_req = 1'b0;
    #1;
    n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL t4_ovf_clr: got %0h want 0", bus.overflow); end
    en_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ram_en === 1'b1) en_cycles++;
      step(); #1;
    end
    n_tests++; if (en_cycles !== 0) begin n_fail++; $display("FAIL t4_fifo_flushed: got %0d ram cycles want 0", en_cycles); end
    step();
  endtask

  task automatic test_load_start_midframe();
    send_byte(8'h11);
    send_byte(8'h22);
    bus.load_start = 1'b1;
    send_byte(8'hAB);
    bus.load_start = 1'b0;
    send_byte(8'hCD);
    send_byte(8'hEF);
    #1;
    n_tests++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 8'd0, 12'hABC}) begin n_fail++; $display("FAIL t6_wr0: got %h want 100abc", {bus.ram_we, bus.ram_addr, bus.ram_wdata}); end
    step(); #1;
    n_tests++; if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {1'b1, 8'd1, 12'hDEF}) begin n_fail++; $display("FAIL t6_wr1: got %h want 101def", {bus.ram_we, bus.ram_addr, bus.ram_wdata}); end
    step(); #1;
    n_tests++; if (bus.word_count !== 9'd2) begin n_fail++; $display("FAIL t6_count: got %0d want 2", bus.word_count); end
    n_tests++; if (ram_mem[0] !== 12'hABC) begin n_fail++; $display("FAIL t6_mem0: got %h want abc", ram_mem[0]); end
    step();
  endtask

  // AW=2 instance: 4 words fill it, the next pair is discarded.
  task automatic test_mem_full();
    logic [7:0]  b5 [9];
    logic [11:0] exp5 [4];
    int n;
    int en_cycles;
    b5   = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCC, 8'hDD, 8'hEE};
    exp5 = '{12'h012, 12'h345, 12'h678, 12'h9AB};
    n = 0;
    for (int c = 0; c < 14; c++) begin
      bus2.rx_valid = (c < 6);
      bus2.rx_byte  = (c < 6) ? b5[c] : 8'h00;
      #1;
      if (bus2.ram_we === 1'b1) begin
        if (n < 4) begin
          n_tests++; if ({bus2.ram_addr, bus2.ram_wdata} !== {2'(n), exp5[n]}) begin n_fail++; $display("FAIL t5_wr%0d: got %h want %h", n, {bus2.ram_addr, bus2.ram_wdata}, {2'(n), exp5[n]}); end
        end
        n++;
      end
      step();
    end
    bus2.rx_valid = 1'b0;
    #1;
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL t5_nwrites: got %0d want 4", n); end
    n_tests++; if ({bus2.mem_full, bus2.word_count} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL t5_full: got %h want c", {bus2.mem_full, bus2.word_count}); end
    en_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      bus2.rx_valid = (c < 3);
      bus2.rx_byte  = (c < 3) ? b5[6 + c] : 8'h00;
      #1;
      if (bus2.ram_en === 1'b1) en_cycles++;
      step();
    end
    bus2.rx_valid = 1'b0;
    #1;
    n_tests++; if (en_cycles !== 0) begin n_fail++; $display("FAIL t5_extra_writes: got %0d want 0", en_cycles); end
    n_tests++; if ({bus2.mem_full, bus2.word_count} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL t5_still_full: got %h want c", {bus2.mem_full, bus2.word_count}); end
    step();
  endtask

  task automatic test_async_reset();
    bus.play_req = 1'b1; bus.play_addr = 8'd1;
    step();
    bus.play_req = 1'b0;
    #1;
    n_tests++; if (bus.play_valid !== 1'b1) begin n_fail++; $display("FAIL ar_valid_before: got %0h want 1", bus.play_valid); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.play_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_abort: got %0h want 0", bus.play_valid); end
    n_tests++; if (bus.word_count !== 9'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", bus.word_count); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_pack_write();
    test_read();
    test_starvation();
    test_overflow();
    test_load_start_midframe();
    test_mem_full();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
